// File: rtl/bmp_loader_if.sv
// SDRAM write port of the BMP loader: toggle req/ack handshake carrying one
// 32-bit pixel word and its framebuffer word address.
`timescale 1ns/1ps
interface bmp_loader_if;
   logic        mem_req;
   logic        mem_ack;
   logic [21:0] mem_addr;
   logic [31:0] mem_din;

   modport master (output mem_req, output mem_addr, output mem_din, input mem_ack);
   modport slave  (input mem_req, input mem_addr, input mem_din, output mem_ack);
endinterface

// File: rtl/bmp_loader.sv
// Streams a BMP from the ioctl byte port into a LINE_WORDS-pitch SDRAM framebuffer.
// Define BMP_ALPHA32_EN to also accept 32 bpp (B,G,R,A) images.
`timescale 1ns/1ps
module bmp_loader #(
   parameter logic [7:0] BMP_INDEX  = 8'd0,
   parameter int         LINE_WORDS = 512,
   parameter int         MAX_LINES  = 512,
   parameter int         FIFO_DEPTH = 4
) (
   input  logic        clk_sys,
   input  logic        reset_n,
   input  logic        ioctl_download,
   input  logic [7:0]  ioctl_index,
   input  logic        ioctl_wr,
   input  logic [24:0] ioctl_addr,
   input  logic [7:0]  ioctl_dout,
   bmp_loader_if.master mem,
   output logic [15:0] bmp_width,
   output logic [15:0] bmp_height,
   output logic        bmp_loaded,
   output logic        bmp_error,
   output logic        busy
);
   localparam int LW_BITS = $clog2(LINE_WORDS);
   localparam int PTR_W   = $clog2(FIFO_DEPTH);
   localparam logic [PTR_W:0] FIFO_FULL = (PTR_W+1)'(FIFO_DEPTH);

   typedef enum logic [2:0] {S_IDLE, S_HEADER, S_SKIP, S_PIXELS, S_DRAIN, S_DONE, S_ERROR} state_t;
   state_t state;

   logic        wr_d, dl_d, sig_ok, issue;
   logic [23:0] data_start;
   logic [7:0]  bpp_lo, b_byte, g_byte;
   logic [1:0]  sel;
   logic [15:0] col, row;
   logic [18:0] row_pos;
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [PTR_W:0]   count;
   logic [53:0] fifo_mem [FIFO_DEPTH];

   logic        dl_q, dl_rise, dl_fall, byte_ok, pix_byte, in_data, in_range;
   logic        push_due, do_push, do_pop, overflow, bpp_good;
   logic [15:0] hdr_bpp, srow;
   logic [18:0] w3, pix_bytes, row_bytes;
   logic [1:0]  last_sel;
   logic [21:0] push_addr;

   assign dl_q     = ioctl_download && (ioctl_index == BMP_INDEX);
   assign dl_rise  = dl_q && !dl_d;
   assign dl_fall  = !dl_q && dl_d;
   assign byte_ok  = ioctl_wr && !wr_d && dl_q;
   assign hdr_bpp  = {ioctl_dout, bpp_lo};
   assign w3       = 19'({bmp_width, 1'b0}) + 19'(bmp_width);

`ifdef BMP_ALPHA32_EN
   logic px32;
   assign pix_bytes = px32 ? 19'({bmp_width, 2'b00}) : w3;
   assign row_bytes = px32 ? pix_bytes : ((w3 + 19'd3) & ~19'd3);
   assign last_sel  = px32 ? 2'd3 : 2'd2;
   assign bpp_good  = (hdr_bpp == 16'd24) || (hdr_bpp == 16'd32);
`else
   assign pix_bytes = w3;
   assign row_bytes = (w3 + 19'd3) & ~19'd3;
   assign last_sel  = 2'd2;
   assign bpp_good  = (hdr_bpp == 16'd24);
`endif

   // The byte landing on data_start in SKIP is already pixel byte 0.
   assign pix_byte  = byte_ok && (state == S_PIXELS ||
                      (state == S_SKIP && ioctl_addr == {1'b0, data_start}));
   assign in_data   = row_pos < pix_bytes;
   assign srow      = bmp_height - 16'd1 - row;
   assign in_range  = ({16'd0, col} < LINE_WORDS) && ({16'd0, srow} < MAX_LINES);
   assign push_addr = (22'(srow) << LW_BITS) | 22'(col[LW_BITS-1:0]);
   assign push_due  = pix_byte && in_data && (sel == 2'd2) && in_range;
   assign do_push   = push_due && (count != FIFO_FULL);
   assign overflow  = push_due && (count == FIFO_FULL);
   assign do_pop    = (count != '0) && (mem.mem_req == mem.mem_ack) && !issue;

   // NOTE: the FIFO storage has no reset; only the pointers and count define its contents.
   always_ff @(posedge clk_sys) begin
      if (do_push) fifo_mem[wr_ptr] <= {push_addr, 8'h00, ioctl_dout, g_byte, b_byte};
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state <= S_IDLE;
         wr_d <= 1'b0;  dl_d <= 1'b0;  sig_ok <= 1'b0;  issue <= 1'b0;
         data_start <= '0;  bpp_lo <= '0;  b_byte <= '0;  g_byte <= '0;
         sel <= '0;  col <= '0;  row <= '0;  row_pos <= '0;
         wr_ptr <= '0;  rd_ptr <= '0;  count <= '0;
         mem.mem_req <= 1'b0;  mem.mem_addr <= '0;  mem.mem_din <= '0;
         bmp_width <= '0;  bmp_height <= '0;
         bmp_loaded <= 1'b0;  bmp_error <= 1'b0;  busy <= 1'b0;
`ifdef BMP_ALPHA32_EN
         px32 <= 1'b0;
`endif
      end else begin
         wr_d <= ioctl_wr;
         dl_d <= dl_q;

         // Request is toggled one cycle after the head word is loaded onto the bus.
         if (issue) begin
            mem.mem_req <= ~mem.mem_req;
            issue       <= 1'b0;
         end
         if (do_pop) begin
            mem.mem_addr <= fifo_mem[rd_ptr][53:32];
            mem.mem_din  <= fifo_mem[rd_ptr][31:0];
            rd_ptr       <= rd_ptr + 1'b1;
            issue        <= 1'b1;
         end
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_push && !do_pop) count <= count + 1'b1;
         else if (!do_push && do_pop) count <= count - 1'b1;
         if (overflow) bmp_error <= 1'b1;

         if (pix_byte) begin
            if (in_data) begin
               if (sel == 2'd0) b_byte <= ioctl_dout;
               if (sel == 2'd1) g_byte <= ioctl_dout;
               sel <= (sel == last_sel) ? 2'd0 : sel + 2'd1;
               if (sel == 2'd2) col <= col + 16'd1;
            end
            if (row_pos + 19'd1 == row_bytes) begin
               row_pos <= '0;
               col     <= '0;
               sel     <= '0;
               row     <= row + 16'd1;
            end else begin
               row_pos <= row_pos + 19'd1;
            end
         end

         case (state)
            S_IDLE, S_DONE, S_ERROR: begin
               if (dl_rise) begin
                  state <= S_HEADER;  busy <= 1'b1;
                  bmp_loaded <= 1'b0;  bmp_error <= 1'b0;  sig_ok <= 1'b0;
                  data_start <= '0;  bpp_lo <= '0;  bmp_width <= '0;  bmp_height <= '0;
                  sel <= '0;  col <= '0;  row <= '0;  row_pos <= '0;
               end
            end
            S_HEADER: begin
               if (dl_fall) begin
                  state <= S_ERROR;  busy <= 1'b0;  bmp_error <= 1'b1;
               end else if (byte_ok) begin
                  case (ioctl_addr)
                     25'd0:  sig_ok <= (ioctl_dout == 8'h42);
                     25'd1:  sig_ok <= sig_ok && (ioctl_dout == 8'h4D);
                     25'd10: data_start[7:0]   <= ioctl_dout;
                     25'd11: data_start[15:8]  <= ioctl_dout;
                     25'd12: data_start[23:16] <= ioctl_dout;
                     25'd18: bmp_width[7:0]    <= ioctl_dout;
                     25'd19: bmp_width[15:8]   <= ioctl_dout;
                     25'd22: bmp_height[7:0]   <= ioctl_dout;
                     25'd23: bmp_height[15:8]  <= ioctl_dout;
                     25'd28: bpp_lo            <= ioctl_dout;
                     25'd29: begin
`ifdef BMP_ALPHA32_EN
                        px32 <= (hdr_bpp == 16'd32);
`endif
                        if (!sig_ok || !bpp_good) begin
                           state <= S_ERROR;  busy <= 1'b0;  bmp_error <= 1'b1;
                        end else if (data_start <= 24'd29) begin
                           state <= S_PIXELS;
                        end else begin
                           state <= S_SKIP;
                        end
                     end
                     default: ;
                  endcase
               end
            end
            S_SKIP: begin
               if (dl_fall) begin
                  state <= S_ERROR;  busy <= 1'b0;  bmp_error <= 1'b1;
               end else if (pix_byte) begin
                  state <= S_PIXELS;
               end
            end
            S_PIXELS: if (dl_fall) state <= S_DRAIN;
            S_DRAIN: begin
               if (count == '0 && mem.mem_req == mem.mem_ack && !issue) begin
                  busy <= 1'b0;
                  if (bmp_error) state <= S_ERROR;
                  else begin
                     state      <= S_DONE;
                     bmp_loaded <= 1'b1;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_bmp_loader.sv
// Directed bench for bmp_loader: table of BMP files streamed through ioctl,
// an echoing SDRAM model, and hand-written reset / wrong-index sequences.
`timescale 1ns/1ps
module tb_bmp_loader;
   logic        clk_sys = 1'b0;
   logic        reset_n = 1'b0;
   logic        ioctl_download = 1'b0;
   logic [7:0]  ioctl_index = 8'd0;
   logic        ioctl_wr = 1'b0;
   logic [24:0] ioctl_addr = '0;
   logic [7:0]  ioctl_dout = '0;
   logic [15:0] bmp_width, bmp_height;
   logic        bmp_loaded, bmp_error, busy;

   bmp_loader_if mif ();

   bmp_loader dut (
      .clk_sys(clk_sys), .reset_n(reset_n),
      .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
      .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
      .mem(mif),
      .bmp_width(bmp_width), .bmp_height(bmp_height),
      .bmp_loaded(bmp_loaded), .bmp_error(bmp_error), .busy(busy)
   );

   always #5 clk_sys = ~clk_sys;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // SDRAM model: acks a request ack_dly falling edges after it appears,
   // logs the word written and counts any bus change while pending.
   int          ack_dly = 3;
   int          ack_cnt = 0;
   int          stab_err = 0;
   logic [21:0] p_addr;
   logic [31:0] p_din;
   logic [21:0] log_addr [$];
   logic [31:0] log_din  [$];

   always @(negedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         mif.mem_ack = 1'b0;
         ack_cnt = 0;
      end else if (mif.mem_req !== mif.mem_ack) begin
         if (ack_cnt == 0) begin
            p_addr = mif.mem_addr;
            p_din  = mif.mem_din;
         end else if (mif.mem_addr !== p_addr || mif.mem_din !== p_din) begin
            stab_err++;
         end
         ack_cnt++;
         if (ack_cnt >= ack_dly) begin
            log_addr.push_back(mif.mem_addr);
            log_din.push_back(mif.mem_din);
            mif.mem_ack = mif.mem_req;
            ack_cnt = 0;
         end
      end
   end

   typedef struct {
      string name;
      int    w, h, bpp, ds, dly;
      bit    sig_bad;
      int    exp_n;        // expected write count, -1 = not checked
      bit    exp_loaded, exp_error;
   } case_t;

   case_t tbl [7];

   byte unsigned fb [$];
   logic [21:0]  ea [$];
   logic [31:0]  ed [$];

   // File bytes and expected writes. Pixel (r,c): B = r*37 + c*3 + 1, G = B+1, R = B+2.
   task automatic build(input case_t tc);
      int data_pos, bpb, rb, base, c, s;
      fb.delete(); ea.delete(); ed.delete();
      data_pos = (tc.ds > 29) ? tc.ds : 30;
      for (int i = 0; i < data_pos; i++) fb.push_back(8'h00);
      fb[0]  = tc.sig_bad ? 8'h58 : 8'h42;
      fb[1]  = 8'h4D;
      fb[10] = 8'(tc.ds);      fb[11] = 8'(tc.ds >> 8);  fb[12] = 8'(tc.ds >> 16);
      fb[18] = 8'(tc.w);       fb[19] = 8'(tc.w >> 8);
      fb[22] = 8'(tc.h);       fb[23] = 8'(tc.h >> 8);
      fb[28] = 8'(tc.bpp);     fb[29] = 8'(tc.bpp >> 8);
      bpb = (tc.bpp == 32) ? 4 : 3;
      rb  = (tc.bpp == 32) ? tc.w * 4 : ((tc.w * 3 + 3) / 4) * 4;
      for (int r = 0; r < tc.h; r++) begin
         for (int k = 0; k < rb; k++) begin
            c = k / bpb;
            s = k % bpb;
            if (k < tc.w * bpb) begin
               base = r * 37 + c * 3 + 1;
               fb.push_back((s == 3) ? 8'hFF : 8'(base + s));
               if (s == 2 && c < 512 && (tc.h - 1 - r) < 512) begin
                  ea.push_back(22'((tc.h - 1 - r) * 512 + c));
                  ed.push_back({8'h00, 8'(base + 2), 8'(base + 1), 8'(base)});
               end
            end else begin
               fb.push_back(8'h00);
            end
         end
      end
   endtask

   task automatic send_byte(input int a, input byte unsigned d);
      @(negedge clk_sys);
      ioctl_addr = 25'(a);
      ioctl_dout = d;
      ioctl_wr   = 1'b1;
      @(negedge clk_sys);
      ioctl_wr   = 1'b0;
   endtask

   task automatic run_case(input case_t tc);
      int log0, st0;
      build(tc);
      log0 = log_addr.size();
      st0  = stab_err;
      ack_dly = tc.dly;
      @(negedge clk_sys);
      ioctl_index = 8'd0;
      ioctl_download = 1'b1;
      @(negedge clk_sys);
      for (int i = 0; i < fb.size(); i++) send_byte(i, fb[i]);
      @(negedge clk_sys);
      ioctl_download = 1'b0;
      repeat (3) @(negedge clk_sys);
      for (int cyc = 0; cyc < 20000 && busy; cyc++) @(negedge clk_sys);
      check({tc.name, " busy_done"}, busy, 0);
      check({tc.name, " loaded"}, bmp_loaded, tc.exp_loaded);
      check({tc.name, " error"}, bmp_error, tc.exp_error);
      check({tc.name, " width"}, bmp_width, tc.w);
      check({tc.name, " height"}, bmp_height, tc.h);
      check({tc.name, " bus_stable"}, stab_err - st0, 0);
      if (tc.exp_n >= 0) begin
         check({tc.name, " n_writes"}, log_addr.size() - log0, tc.exp_n);
         for (int i = 0; i < ea.size() && log0 + i < log_addr.size(); i++) begin
            check($sformatf("%s addr[%0d]", tc.name, i), log_addr[log0 + i], ea[i]);
            check($sformatf("%s data[%0d]", tc.name, i), log_din[log0 + i], ed[i]);
         end
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      tbl[0] = '{"bmp2x2",   2,   2, 24, 54,  3, 1'b0,  4, 1'b1, 1'b0};
      tbl[1] = '{"bad_sig",  2,   2, 24, 54,  3, 1'b1,  0, 1'b0, 1'b1};
      tbl[2] = '{"bpp8",     2,   2,  8, 54,  3, 1'b0,  0, 1'b0, 1'b1};
      tbl[3] = '{"skip_gap", 3,   1, 24, 60,  3, 1'b0,  3, 1'b1, 1'b0};
      tbl[4] = '{"ds_low",   1,   3, 24, 26,  3, 1'b0,  3, 1'b1, 1'b0};
      tbl[5] = '{"wide600",  600, 1, 24, 54,  3, 1'b0, 512, 1'b1, 1'b0};
      tbl[6] = '{"overflow", 16,  1, 24, 54, 40, 1'b0, -1, 1'b0, 1'b1};

      repeat (2) @(negedge clk_sys);
      check("rst mem_req", mif.mem_req, 0);
      reset_n = 1'b1;
      @(negedge clk_sys);
      check("rst mem_addr", mif.mem_addr, 0);
      check("rst mem_din", mif.mem_din, 0);
      check("rst width", bmp_width, 0);
      check("rst height", bmp_height, 0);
      check("rst loaded", bmp_loaded, 0);
      check("rst error", bmp_error, 0);
      check("rst busy", busy, 0);

      // A download to another index must be ignored.
      @(negedge clk_sys);
      ioctl_index = 8'd5;
      ioctl_download = 1'b1;
      send_byte(0, 8'h42);
      send_byte(1, 8'h4D);
      @(negedge clk_sys);
      check("other_index busy", busy, 0);
      ioctl_download = 1'b0;
      ioctl_index = 8'd0;
      @(negedge clk_sys);

      for (int t = 0; t < 7; t++) run_case(tbl[t]);

      begin
         case_t a32;
`ifdef BMP_ALPHA32_EN
         a32 = '{"bpp32", 1, 1, 32, 54, 3, 1'b0, 1, 1'b1, 1'b0};
`else
         a32 = '{"bpp32", 1, 1, 32, 54, 3, 1'b0, 0, 1'b0, 1'b1};
`endif
         run_case(a32);
      end

      // Reset in the middle of the pixel stream, then a clean reload.
      build(tbl[0]);
      ack_dly = 3;
      @(negedge clk_sys);
      ioctl_download = 1'b1;
      @(negedge clk_sys);
      for (int i = 0; i < 60; i++) send_byte(i, fb[i]);
      @(negedge clk_sys);
      check("mid busy", busy, 1);
      check("mid width", bmp_width, 2);
      #2 reset_n = 1'b0;
      #1;
      check("async mem_req", mif.mem_req, 0);
      check("async mem_addr", mif.mem_addr, 0);
      check("async mem_din", mif.mem_din, 0);
      check("async width", bmp_width, 0);
      check("async height", bmp_height, 0);
      check("async loaded", bmp_loaded, 0);
      check("async error", bmp_error, 0);
      check("async busy", busy, 0);
      ioctl_download = 1'b0;
      ioctl_wr = 1'b0;
      repeat (2) @(negedge clk_sys);
      reset_n = 1'b1;
      @(negedge clk_sys);
      run_case(tbl[0]);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
